// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uc_pkg
// Purpose  : Shared definitions for the multicycle control unit: FSM state
//            encodings, opcode constants, instruction classes and ALU codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uc_pkg;

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_BRANCH = 3'd3;
  localparam state_t S_HALT   = 3'd4;

  // Opcode constants
  localparam logic [5:0] OP_J       = 6'b000100;
  localparam logic [5:0] OP_JZ      = 6'b000101;
  localparam logic [5:0] OP_JNZ     = 6'b000110;
  localparam logic [5:0] OP_NOP     = 6'b000111;
  localparam logic [3:0] OP_LI_PFX  = 4'b0000;   // 0000xx
  localparam logic       OP_ALU_PFX = 1'b1;      // 1xxxxx

  // ALU operation codes
  localparam logic [2:0] ALU_000 = 3'b000;
  localparam logic [2:0] ALU_001 = 3'b001;
  localparam logic [2:0] ALU_010 = 3'b010;
  localparam logic [2:0] ALU_011 = 3'b011;
  localparam logic [2:0] ALU_100 = 3'b100;
  localparam logic [2:0] ALU_101 = 3'b101;
  localparam logic [2:0] ALU_110 = 3'b110;
  localparam logic [2:0] ALU_111 = 3'b111;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_ALU = 3'd1,
    CLS_LI  = 3'd2,
    CLS_J   = 3'd3,
    CLS_JZ  = 3'd4,
    CLS_JNZ = 3'd5,
    CLS_ILL = 3'd6
  } cls_t;

endpackage
`default_nettype wire

// File: rtl/uc_decode.sv
`default_nettype none
// ============================================================================
// Module   : uc_decode
// Purpose  : Combinational opcode classifier for the multicycle control unit.
// Ports    : op_q   (in,  6) latched opcode
//            cls    (out, cls_t) instruction class
//            op_alu (out, 3) ALU operation, 000 unless ALU class
// Revision : 1.0 - initial release
// ============================================================================
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] op_q,
  output cls_t       cls,
  output logic [2:0] op_alu
);

  always_comb begin
    cls    = CLS_ILL;
    op_alu = ALU_000;
    if (op_q[5] == OP_ALU_PFX) begin
      cls    = CLS_ALU;
      op_alu = op_q[4:2];
    end else if (op_q[5:2] == OP_LI_PFX) begin
      cls = CLS_LI;
    end else begin
      // Remaining space: 0001xx are jumps/NOP, 001xxx and 01xxxx illegal
      case (op_q)
        OP_J:    cls = CLS_J;
        OP_JZ:   cls = CLS_JZ;
        OP_JNZ:  cls = CLS_JNZ;
        OP_NOP:  cls = CLS_NOP;
        default: cls = CLS_ILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo
// Purpose  : Multicycle control unit. FETCH -> DECODE -> EXEC/BRANCH -> FETCH,
//            with an absorbing HALT state for illegal opcodes.
// Ports    : clk, reset (sync, active-high)
//            opcode (6), imem_ack, z        : inputs
//            imem_req, s_inc, s_inm, we3, wez, pc_we, op_alu (3) : strobes
//            halted, retired (CNTW)         : status
// Revision : 1.0 - initial release
// ============================================================================
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNTW            = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic            pc_we,
  output logic [2:0]      op_alu,
  output logic            halted,
  output logic [CNTW-1:0] retired
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t     state, state_nx;
  logic [5:0] op_q;
  cls_t       cls;
  logic [2:0] dec_alu;
  logic       taken;

  // Unqualified strobes from the FSM; reset masks them below
  logic       req_fsm, pc_we_fsm, we3_fsm, wez_fsm, s_inm_fsm, s_inc_fsm;
  logic [2:0] alu_fsm;

  uc_decode u_decode (
    .op_q   (op_q),
    .cls    (cls),
    .op_alu (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= OP_NOP;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack)
        op_q <= opcode;
      // Counter wraps naturally at 2^CNTW
      if (state == S_EXEC || state == S_BRANCH)
        retired <= retired + CNT_ONE;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          CLS_J, CLS_JZ, CLS_JNZ: state_nx = S_BRANCH;
          CLS_ILL:                state_nx = HALT_ON_ILLEGAL ? S_HALT : S_EXEC;
          default:                state_nx = S_EXEC;
        endcase
      end
      S_EXEC:   state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // z is used only here, i.e. only in the BRANCH cycle
  always_comb begin
    case (cls)
      CLS_J:   taken = 1'b1;
      CLS_JZ:  taken = z;
      CLS_JNZ: taken = ~z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    req_fsm   = 1'b0;
    pc_we_fsm = 1'b0;
    we3_fsm   = 1'b0;
    wez_fsm   = 1'b0;
    s_inm_fsm = 1'b0;
    s_inc_fsm = 1'b1;
    alu_fsm   = ALU_000;
    case (state)
      S_FETCH: req_fsm = 1'b1;
      S_DECODE: ;
      S_EXEC: begin
        pc_we_fsm = 1'b1;
        case (cls)
          CLS_ALU: begin
            we3_fsm = 1'b1;
            wez_fsm = 1'b1;
            alu_fsm = dec_alu;
          end
          CLS_LI: begin
            we3_fsm   = 1'b1;
            s_inm_fsm = 1'b1;
          end
          default: ;  // NOP or tolerated illegal: advance PC only
        endcase
      end
      S_BRANCH: begin
        pc_we_fsm = 1'b1;
        s_inc_fsm = ~taken;
      end
      S_HALT: s_inc_fsm = 1'b0;
      default: ;
    endcase
  end

  // Reset aborts an instruction in flight: no write strobe while it is high
  assign imem_req = req_fsm   & ~reset;
  assign pc_we    = pc_we_fsm & ~reset;
  assign we3      = we3_fsm   & ~reset;
  assign wez      = wez_fsm   & ~reset;
  assign s_inm    = s_inm_fsm & ~reset;
  assign s_inc    = s_inc_fsm;
  assign op_alu   = alu_fsm;
  assign halted   = (state == S_HALT) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_multiciclo
// Purpose  : Directed self-checking bench. dut_a uses default parameters,
//            dut_b uses HALT_ON_ILLEGAL=0 and CNTW=2; both share stimulus.
//            Inputs change and outputs are checked on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       z = 1'b0;
  logic       imem_ack = 1'b0;
  logic [5:0] opcode = 6'b000000;

  logic        imem_req_a, s_inc_a, s_inm_a, we3_a, wez_a, pc_we_a, halted_a;
  logic [2:0]  op_alu_a;
  logic [15:0] retired_a;
  logic        imem_req_b, s_inc_b, s_inm_b, we3_b, wez_b, pc_we_b, halted_b;
  logic [2:0]  op_alu_b;
  logic [1:0]  retired_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uc_multiciclo dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .imem_ack(imem_ack),
    .imem_req(imem_req_a), .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a),
    .wez(wez_a), .pc_we(pc_we_a), .op_alu(op_alu_a), .halted(halted_a),
    .retired(retired_a)
  );

  uc_multiciclo #(.CNTW(2), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .imem_ack(imem_ack),
    .imem_req(imem_req_b), .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b),
    .wez(wez_b), .pc_we(pc_we_b), .op_alu(op_alu_b), .halted(halted_b),
    .retired(retired_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a falling edge inside FETCH; ends at the falling edge of the
  // EXEC/BRANCH/HALT cycle that follows DECODE.
  task automatic fetch_op(input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) begin
      check("fetch_wait_req", imem_req_a, 1);
      @(negedge clk);
    end
    check("fetch_req", imem_req_a, 1);
    opcode   = op;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    opcode   = 6'b011111;  // garbage: op_q must hold the latched value
    check("decode_quiet", {imem_req_a, pc_we_a, we3_a, wez_a, s_inm_a, s_inc_a, op_alu_a},
          {6'b000001, 3'b000});
    @(negedge clk);
  endtask

  task automatic branch_op(input logic [5:0] op, input logic zv, input logic exp_inc,
                           input logic [15:0] exp_ret);
    z = ~zv;  // opposite value before the BRANCH cycle
    fetch_op(op, 0);
    z = zv;
    #1;
    check("branch_strobes", {pc_we_a, s_inc_a, we3_a, wez_a}, {1'b1, exp_inc, 2'b00});
    @(negedge clk);
    check("branch_retired", retired_a, exp_ret);
  endtask

  logic [1:0] exp_b [5];

  initial begin
    exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd0; exp_b[4] = 2'd1;

    // Reset
    @(negedge clk);
    check("rst_strobes", {pc_we_a, we3_a, wez_a, imem_req_a}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst", {imem_req_a, pc_we_a, we3_a, wez_a, halted_a}, 5'b10000);
    check("post_rst_retired", retired_a, 0);
    @(negedge clk);

    // ALU 101000 after 4 cycles without ack
    fetch_op(6'b101000, 3);
    check("alu_exec", {we3_a, wez_a, s_inm_a, s_inc_a, pc_we_a}, 5'b11011);
    check("alu_op", op_alu_a, 3'b010);
    @(negedge clk);
    check("alu_retired", retired_a, 1);

    // LI
    fetch_op(6'b000010, 0);
    check("li_exec", {we3_a, wez_a, s_inm_a, s_inc_a, pc_we_a, op_alu_a}, 8'b10111000);
    @(negedge clk);
    check("li_retired", retired_a, 2);

    // Branches
    branch_op(6'b000101, 1'b1, 1'b0, 3);  // JZ taken
    branch_op(6'b000101, 1'b0, 1'b1, 4);  // JZ not taken
    branch_op(6'b000110, 1'b1, 1'b1, 5);  // JNZ not taken
    branch_op(6'b000110, 1'b0, 1'b0, 6);  // JNZ taken
    branch_op(6'b000100, 1'b1, 1'b0, 7);  // J
    branch_op(6'b000100, 1'b0, 1'b0, 8);  // J

    // NOP
    fetch_op(6'b000111, 0);
    check("nop_exec", {we3_a, wez_a, s_inm_a, s_inc_a, pc_we_a}, 5'b00011);
    @(negedge clk);
    check("nop_retired", retired_a, 9);

    // ALU 111111
    fetch_op(6'b111111, 0);
    check("alu7_op", op_alu_a, 3'b111);
    @(negedge clk);
    check("alu7_retired", retired_a, 10);

    // Reset during EXEC of an ALU op
    fetch_op(6'b100100, 0);
    check("abort_pre", {we3_a, op_alu_a}, 4'b1001);
    reset = 1'b1;
    #1;
    check("abort_strobes", {we3_a, wez_a, pc_we_a}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    check("abort_retired_a", retired_a, 0);
    check("abort_retired_b", retired_b, 0);
    @(negedge clk);
    check("abort_fetch", {imem_req_a, pc_we_a, we3_a, wez_a}, 4'b1000);

    // Five NOPs: 2-bit counter wraps
    for (int i = 0; i < 5; i++) begin
      fetch_op(6'b000111, 0);
      @(negedge clk);
      check("wrap_retired_b", retired_b, exp_b[i]);
      check("wrap_retired_a", retired_a, i + 1);
    end

    // Illegal opcode: dut_a halts, dut_b treats it as NOP
    fetch_op(6'b010000, 0);
    check("ill_halt_a", {halted_a, imem_req_a, pc_we_a, we3_a, wez_a, s_inm_a}, 6'b100000);
    check("ill_nop_b", {halted_b, pc_we_b, s_inc_b, we3_b, wez_b}, 5'b01100);
    @(negedge clk);
    check("ill_retired_b", retired_b, 2);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      opcode   = 6'b101000;
      check("halt_hold", {halted_a, imem_req_a, pc_we_a, we3_a}, 4'b1000);
      check("halt_retired", retired_a, 5);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("halt_cleared", {halted_a, imem_req_a}, 2'b01);
    check("halt_cleared_retired", retired_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter CNTW, default 16: width of the retired-instruction counter.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1: 1 = illegal opcode halts the machine; 0 = illegal opcode executes as NOP.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port opcode, input, 6: instruction opcode from instruction memory; valid only while imem_ack=1.
REQ-006 Port z, input, 1: zero flag from the flag register.
REQ-007 Port imem_ack, input, 1: instruction memory returns opcode this cycle.
REQ-008 Port imem_req, output, 1: fetch request to instruction memory.
REQ-009 Ports s_inc, s_inm, we3, wez, output, 1 each: PC-increment select, immediate select, register-file write, flag write.
REQ-010 Port pc_we, output, 1: PC load enable.
REQ-011 Port op_alu, output, 3: ALU operation.
REQ-012 Port halted, output, 1: machine stopped on an illegal opcode.
REQ-013 Port retired, output, CNTW: count of completed instructions.

Function
REQ-014 FSM states: FETCH, DECODE, EXEC, BRANCH, HALT.
REQ-015 FETCH: imem_req=1; stay while imem_ack=0; on imem_ack=1 latch opcode into internal op_q and go to DECODE.
REQ-016 DECODE: all strobes 0; classify op_q; ALU or LI class -> EXEC; J/JZ/JNZ -> BRANCH; NOP class -> EXEC; illegal -> HALT if HALT_ON_ILLEGAL=1, else EXEC as NOP.
REQ-017 Classes: 1xxxxx ALU with op_alu=op_q[4:2]; 0000xx LI; 000100 J; 000101 JZ; 000110 JNZ; 000111 NOP; 001xxx, 01xxxx illegal.
REQ-018 EXEC, ALU class: one cycle of we3=1, wez=1, s_inm=0, s_inc=1, pc_we=1, op_alu=op_q[4:2]; then FETCH.
REQ-019 EXEC, LI class: one cycle of we3=1, wez=0, s_inm=1, s_inc=1, pc_we=1, op_alu=000; then FETCH.
REQ-020 EXEC, NOP or tolerated illegal: one cycle of pc_we=1, s_inc=1, other strobes 0; then FETCH.
REQ-021 BRANCH: one cycle of pc_we=1; taken = J, or JZ with z=1, or JNZ with z=0; s_inc = not taken; we3=wez=0; then FETCH.
REQ-022 z is sampled in the BRANCH cycle, not earlier.
REQ-023 HALT: absorbing; halted=1; all strobes 0; imem_req=0; retired frozen; exit only by reset.
REQ-024 In FETCH and DECODE, pc_we, we3, wez, s_inm = 0, s_inc=1, op_alu=000.
REQ-025 retired increments by 1 on the cycle EXEC or BRANCH completes; wraps from 2^CNTW-1 to 0.
REQ-026 Outputs are a function of state and op_q only; opcode and imem_ack do not reach strobes combinationally.
REQ-027 Latency: 3 cycles per instruction plus FETCH wait cycles.

Reset
REQ-028 reset=1 at any edge forces state FETCH, op_q=000111, retired=0, halted=0, overriding every other event.
REQ-029 During reset and in the first cycle after it, pc_we, we3, wez = 0; imem_req asserts in the first post-reset cycle.
REQ-030 Reset in the middle of an instruction aborts it with no write strobe issued.

Structure
REQ-031 Shared package uc_pkg holds the state enum, the 6-bit opcode constants (J, JZ, JNZ, NOP, LI prefix, ALU prefix), and the ALU operation codes 000-111.
REQ-032 One combinational sub-module, uc_decode, maps op_q to class and op_alu; uc_multiciclo holds the FSM, op_q, and the counter.

Verification
REQ-033 After reset, imem_ack held 0 for 4 cycles then opcode=101000 with ack -> imem_req high for 5 cycles, then DECODE, then EXEC with we3=1, wez=1, op_alu=010, pc_we=1; retired=1.
REQ-034 opcode=000010 -> EXEC with we3=1, s_inm=1, wez=0; retired increments.
REQ-035 JZ (000101) with z=1 -> BRANCH cycle pc_we=1, s_inc=0; with z=0 -> s_inc=1; JNZ (000110) gives the opposite result; J (000100) always s_inc=0.
REQ-036 opcode=010000 with HALT_ON_ILLEGAL=1 -> halted=1 and imem_req=0 permanently until reset; with HALT_ON_ILLEGAL=0 -> NOP, retired increments.
REQ-037 reset asserted in the EXEC cycle of an ALU op -> no we3/wez pulse, retired=0, FETCH next.
REQ-038 CNTW=2, 5 NOPs -> retired sequence 1, 2, 3, 0, 1.
